// File: rtl/cpu_trace_buffer.sv
// Instruction trace buffer: circular capture of retired-instruction samples
// around a trigger, followed by oldest-first readout.
module cpu_trace_buffer #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     trig,
    input  logic                     valid_in,
    input  logic [XLEN-1:0]          PC_in,
    input  logic [XLEN-1:0]          instr_in,
    input  logic [XLEN-1:0]          ALUres_in,
    input  logic                     rd_en,
    output logic [XLEN-1:0]          rd_PC,
    output logic [XLEN-1:0]          rd_instr,
    output logic [XLEN-1:0]          rd_ALUres,
    output logic                     rd_valid,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wrapped
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);
    localparam logic NO_POST = (POST_TRIG == 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     w_wp_nx;
    logic [AW-1:0]     r_rp;
    logic [AW-1:0]     w_rp_nx;
    logic [AW:0]       r_count;
    logic [AW:0]       w_count_nx;
    logic              r_wrapped;
    logic              w_wrapped_nx;
    logic [AW-1:0]     r_post;
    logic [AW-1:0]     w_post_nx;
    logic              w_we;
    logic              w_rd_fire;

    logic [3*XLEN-1:0] r_mem [DEPTH];
    logic              r_rd_valid;
    logic [XLEN-1:0]   r_rd_pc;
    logic [XLEN-1:0]   r_rd_instr;
    logic [XLEN-1:0]   r_rd_alu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_wrapped <= 1'b0;
            r_post    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_wp      <= w_wp_nx;
            r_rp      <= w_rp_nx;
            r_count   <= w_count_nx;
            r_wrapped <= w_wrapped_nx;
            r_post    <= w_post_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_wp_nx      = r_wp;
        w_rp_nx      = r_rp;
        w_count_nx   = r_count;
        w_wrapped_nx = r_wrapped;
        w_post_nx    = r_post;
        w_we         = 1'b0;
        w_rd_fire    = 1'b0;
        if (arm) begin
            w_state_nx   = S_ARMED;
            w_wp_nx      = '0;
            w_rp_nx      = '0;
            w_count_nx   = '0;
            w_wrapped_nx = 1'b0;
            w_post_nx    = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                end
                S_ARMED, S_POST: begin
                    if (valid_in) begin
                        w_we    = 1'b1;
                        w_wp_nx = r_wp + 1'b1;
                        // Full buffer: oldest entry is overwritten in place
                        if (r_count == FULL) begin
                            w_wrapped_nx = 1'b1;
                        end else begin
                            w_count_nx = r_count + 1'b1;
                        end
                        if (r_state == S_ARMED) begin
                            if (trig) begin
                                if (NO_POST) begin
                                    w_state_nx = S_DONE;
                                end else begin
                                    w_state_nx = S_POST;
                                    w_post_nx  = POST_INIT;
                                end
                            end
                        end else begin
                            w_post_nx = r_post - 1'b1;
                            if (r_post == AW'(1)) begin
                                w_state_nx = S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (rd_en && (r_count != '0)) begin
                        w_rd_fire  = 1'b1;
                        w_rp_nx    = r_rp + 1'b1;
                        w_count_nx = r_count - 1'b1;
                    end
                end
                default: begin
                end
            endcase
            // Point readout at the oldest surviving entry
            if ((w_state_nx == S_DONE) && (r_state != S_DONE)) begin
                w_rp_nx = w_wp_nx - w_count_nx[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wp] <= {PC_in, instr_in, ALUres_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_pc    <= '0;
            r_rd_instr <= '0;
            r_rd_alu   <= '0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_pc    <= r_mem[r_rp][3*XLEN-1:2*XLEN];
                r_rd_instr <= r_mem[r_rp][2*XLEN-1:XLEN];
                r_rd_alu   <= r_mem[r_rp][XLEN-1:0];
            end
        end
    end

    assign state     = r_state;
    assign count     = r_count;
    assign wrapped   = r_wrapped;
    assign rd_valid  = r_rd_valid;
    assign rd_PC     = r_rd_pc;
    assign rd_instr  = r_rd_instr;
    assign rd_ALUres = r_rd_alu;

endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, meaning the width of each captured field.
REQ-002 The block SHALL take parameter DEPTH, default 16, meaning the number of trace entries; power of 2, at least 4.
REQ-003 The block SHALL take parameter POST_TRIG, default 8, meaning the number of valid samples captured after the trigger sample; range 0..DEPTH-1.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port arm, input, 1 bit, a one-cycle pulse that starts a capture.
REQ-007 The block SHALL have port trig, input, 1 bit, the trigger qualifier, sampled only together with valid_in.
REQ-008 The block SHALL have port valid_in, input, 1 bit, meaning a retired instruction this cycle.
REQ-009 The block SHALL have ports PC_in, instr_in and ALUres_in, inputs, XLEN bits each, the sample fields.
REQ-010 The block SHALL have port rd_en, input, 1 bit, a readout request.
REQ-011 The block SHALL have ports rd_PC, rd_instr and rd_ALUres, outputs, XLEN bits each, the readout data.
REQ-012 The block SHALL have port rd_valid, output, 1 bit, meaning the readout data is valid this cycle.
REQ-013 The block SHALL have port state, output, 2 bits: IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH)+1 bits, the number of unread stored entries.
REQ-015 The block SHALL have port wrapped, output, 1 bit, set when pre-trigger samples have overwritten older entries.

Function
REQ-016 The block SHALL store each entry as {PC, instr, ALUres} in a circular array of DEPTH entries, with write pointer wp and read pointer rp, both $clog2(DEPTH) bits and wrapping modulo DEPTH.
REQ-017 In IDLE, the block SHALL ignore valid_in and trig; arm moves it to ARMED and clears wp, count and wrapped.
REQ-018 In ARMED, each valid_in SHALL write the sample at wp and increment wp; count saturates at DEPTH; a write while count==DEPTH sets wrapped and overwrites the oldest entry.
REQ-019 In ARMED, valid_in&&trig SHALL store the trigger sample, then go to POST with the post counter = POST_TRIG; if POST_TRIG==0, go directly to DONE.
REQ-020 In POST, each valid_in SHALL be written as in REQ-018 and decrement the post counter; the write that takes it to 0 moves the block to DONE; trig is ignored in POST.
REQ-021 On entry to DONE, the block SHALL set rp = wp - count (mod DEPTH), pointing at the oldest entry; no further writes occur in DONE.
REQ-022 In DONE, rd_en with count>0 SHALL present the entry at rp on the rd_* outputs with rd_valid=1 on the next cycle, then increment rp and decrement count; one-cycle latency; back-to-back rd_en gives one entry per cycle.
REQ-023 rd_en with count==0, or rd_en outside DONE, SHALL produce rd_valid=0 on the next cycle and change no state.
REQ-024 The rd_* data outputs SHALL hold their last values while rd_valid=0.
REQ-025 arm SHALL be accepted in any state, restarting as in REQ-017 and discarding unread entries; arm has priority over valid_in, trig and rd_en in the same cycle, and that cycle's sample is not stored.
REQ-026 The block SHALL store only a trigger that coincides with valid_in; trig without valid_in has no effect.

Reset
REQ-027 While reset is high, the block SHALL force state=IDLE, wp=rp=0, count=0, wrapped=0, post counter=0, rd_valid=0 and rd_PC=rd_instr=rd_ALUres=0; array contents need not be cleared.
REQ-028 Reset asserted in any state, including mid-POST or mid-readout, SHALL abort the activity immediately, asynchronously, with no completion.

Verification (DEPTH=16, POST_TRIG=8)
REQ-029 Reset -> state=0, count=0, rd_valid=0, wrapped=0, rd_PC=0.
REQ-030 arm, then 33 consecutive valid samples PC=0x00,0x04,..,0x80 with trig on PC=0x60 -> DONE after PC=0x80, count=16, wrapped=1; 16 rd_en give rd_PC 0x44..0x80 in order; a 17th rd_en gives rd_valid=0.
REQ-031 Early trigger: arm, samples PC=0x0,0x4,0x8, trig on PC=0xC, 8 more samples -> count=12, wrapped=0; readout gives PC 0x0..0x2C.
REQ-032 valid_in low for 5 cycles inside POST -> the post counter does not decrement and DONE is reached only after 8 valid post samples.
REQ-033 In IDLE, arm and trig with valid_in in the same cycle -> state=ARMED, count=0, no trigger taken.
REQ-034 reset pulse during POST with count=10 -> state=IDLE and count=0 immediately; a later rd_en gives rd_valid=0.
